// File: rtl/pga_autorange.sv
// PGA autorange: fast-attack gain step-down on near-clip samples, slow-release step-up after quiet windows.
// Outputs register on the edge after a newdata cycle; no backpressure, every strobe is consumed.
module pga_autorange #(
  parameter int          WINDOW     = 1024,
  parameter int          SETTLE     = 64,
  parameter logic [15:0] HI_THR     = 16'd30720,
  parameter logic [15:0] LO_THR     = 16'd6144,
  parameter int          UP_WINDOWS = 4
) (
  input  logic        CLK36,
  input  logic        rst,
  input  logic        newdata,
  input  logic [15:0] adcdata,
  input  logic        auto_en,
  input  logic [1:0]  manual_gain,
  output logic [1:0]  gain,
  output logic        settling,
  output logic        overrange,
  output logic        range_changed,
  output logic [15:0] peak
);

  localparam int SCW = $clog2(WINDOW);
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int LCW = $clog2(UP_WINDOWS + 1);
  localparam logic [SCW-1:0] WIN_LAST = SCW'(WINDOW - 1);
  localparam logic [STW-1:0] SET_LAST = STW'(SETTLE - 1);
  localparam logic [LCW-1:0] UP_N     = LCW'(UP_WINDOWS);

  typedef enum logic [1:0] {ST_MANUAL, ST_MEASURE, ST_SETTLE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     gain_d;
  logic [15:0]    peak_d, run_peak, run_peak_d, mag, win_peak;
  logic [SCW-1:0] sample_cnt, sample_cnt_d;
  logic [STW-1:0] settle_cnt, settle_cnt_d;
  logic [LCW-1:0] low_cnt, low_cnt_d, low_next;
  logic           ovr_d, rc_d, near_clip;

  // -32768 has no positive twin; saturate it to full scale.
  always_comb begin
    mag = adcdata;
    if (adcdata == 16'h8000) mag = 16'h7FFF;
    else if (adcdata[15])    mag = ~adcdata + 16'd1;
  end

  assign near_clip = (mag >= HI_THR);
  assign win_peak  = (mag > run_peak) ? mag : run_peak;
  assign low_next  = (win_peak < LO_THR) ? ((low_cnt == UP_N) ? UP_N : low_cnt + LCW'(1)) : '0;
  assign settling  = (state_q == ST_SETTLE);

  always_comb begin
    state_d      = state_q;
    gain_d       = gain;
    peak_d       = peak;
    run_peak_d   = run_peak;
    sample_cnt_d = sample_cnt;
    settle_cnt_d = settle_cnt;
    low_cnt_d    = low_cnt;
    ovr_d        = 1'b0;
    rc_d         = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        if (auto_en) begin
          state_d      = ST_MEASURE;
          sample_cnt_d = '0;
          run_peak_d   = '0;
          low_cnt_d    = '0;
        end else begin
          gain_d = manual_gain;
        end
      end
      ST_MEASURE: begin
        if (!auto_en) begin
          state_d = ST_MANUAL;
          gain_d  = manual_gain;
        end else if (newdata) begin
          if (near_clip && gain != 2'd0) begin
            gain_d       = gain - 2'd1;
            rc_d         = 1'b1;
            low_cnt_d    = '0;
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end else begin
            // At minimum gain a near-clip sample is flagged but still measured.
            ovr_d = near_clip;
            if (sample_cnt == WIN_LAST) begin
              peak_d       = win_peak;
              run_peak_d   = '0;
              sample_cnt_d = '0;
              if (low_next == UP_N && gain != 2'd3) begin
                gain_d       = gain + 2'd1;
                rc_d         = 1'b1;
                low_cnt_d    = '0;
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
              end else begin
                low_cnt_d = low_next;
              end
            end else begin
              run_peak_d   = win_peak;
              sample_cnt_d = sample_cnt + SCW'(1);
            end
          end
        end
      end
      ST_SETTLE: begin
        if (!auto_en) begin
          state_d = ST_MANUAL;
          gain_d  = manual_gain;
        end else if (newdata) begin
          if (settle_cnt == SET_LAST) begin
            state_d      = ST_MEASURE;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            run_peak_d   = '0;
          end else begin
            settle_cnt_d = settle_cnt + STW'(1);
          end
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  always_ff @(posedge CLK36) begin
    if (rst) begin
      state_q       <= ST_MANUAL;
      gain          <= 2'd0;
      peak          <= '0;
      run_peak      <= '0;
      sample_cnt    <= '0;
      settle_cnt    <= '0;
      low_cnt       <= '0;
      overrange     <= 1'b0;
      range_changed <= 1'b0;
    end else begin
      state_q       <= state_d;
      gain          <= gain_d;
      peak          <= peak_d;
      run_peak      <= run_peak_d;
      sample_cnt    <= sample_cnt_d;
      settle_cnt    <= settle_cnt_d;
      low_cnt       <= low_cnt_d;
      overrange     <= ovr_d;
      range_changed <= rc_d;
    end
  end

endmodule
